// File: rtl/pkg_Axi4Types.sv
`default_nettype none
// ============================================================================
// Package  : pkg_Axi4Types
// Purpose  : Shared AXI4 encodings. Holds the burst types, the response
//            codes and the state enums of the write and read responder FSMs.
// Revision : 1.0 - initial release
// ============================================================================
package pkg_Axi4Types;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi4_burst_addr.sv
`default_nettype none
// ============================================================================
// Module   : axi4_burst_addr
// Purpose  : Combinational AXI4 next-beat address for FIXED, INCR and WRAP
//            bursts. Burst code 3 follows the INCR rule.
// Ports    : addr      in  A   current beat address
//            len       in  8   burst length minus one (WRAP: 1, 3, 7, 15)
//            size      in  3   log2 of bytes per beat
//            burst     in  2   burst type
//            next_addr out A   address of the following beat
// Revision : 1.0 - initial release
// ============================================================================
module axi4_burst_addr
    import pkg_Axi4Types::*;
#(
    parameter int A = 32
) (
    input  logic [A-1:0] addr,
    input  logic [7:0]   len,
    input  logic [2:0]   size,
    input  logic [1:0]   burst,
    output logic [A-1:0] next_addr
);

    logic [A-1:0] w_step;
    logic [A-1:0] w_aligned;
    logic [A-1:0] w_incr;
    logic [A-1:0] w_wrap_mask;

    always_comb begin
        w_step      = A'(1) << size;
        w_aligned   = addr & ~(w_step - A'(1));
        w_incr      = w_aligned + w_step;
        // Window of (len+1)<<size bytes; it is a power of two for legal WRAP lengths.
        w_wrap_mask = ((A'(len) + A'(1)) << size) - A'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
            default:     next_addr = w_incr;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi4_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : axi4_slave_mem
// Purpose  : AXI4 memory responder. Independent write and read FSMs, one
//            burst in flight on each, backed by a word-addressed RAM of
//            2**DEPTH_LOG2 words of N bytes. Upper address bits alias.
// Ports    : ACLK/ARESET             clock, async active-high reset
//            AW*  (in, AWREADY out)  write address channel
//            W*   (in, WREADY out)   write data channel
//            B*   (out, BREADY in)   write response channel
//            AR*  (in, ARREADY out)  read address channel
//            R*   (out, RREADY in)   read data channel
// Config   : AXI4_SLAVE_MEM_RANGE_CHK_EN - beats addressing beyond the RAM
//            get SLVERR; such writes are dropped and such reads return 0.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_slave_mem
    import pkg_Axi4Types::*;
#(
    parameter int N          = 8,
    parameter int I          = 8,
    parameter int A          = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic           ACLK,
    input  logic           ARESET,
    input  logic [I-1:0]   AWID,
    input  logic [A-1:0]   AWADDR,
    input  logic [7:0]     AWLEN,
    input  logic [2:0]     AWSIZE,
    input  logic [1:0]     AWBURST,
    input  logic           AWLOCK,
    input  logic [3:0]     AWCACHE,
    input  logic [2:0]     AWPROT,
    input  logic [3:0]     AWQOS,
    input  logic [3:0]     AWREGION,
    input  logic           AWVALID,
    output logic           AWREADY,
    input  logic [8*N-1:0] WDATA,
    input  logic [N-1:0]   WSTRB,
    input  logic           WLAST,
    input  logic           WVALID,
    output logic           WREADY,
    output logic [I-1:0]   BID,
    output logic [1:0]     BRESP,
    output logic           BVALID,
    input  logic           BREADY,
    input  logic [I-1:0]   ARID,
    input  logic [A-1:0]   ARADDR,
    input  logic [7:0]     ARLEN,
    input  logic [2:0]     ARSIZE,
    input  logic [1:0]     ARBURST,
    input  logic           ARLOCK,
    input  logic [3:0]     ARCACHE,
    input  logic [2:0]     ARPROT,
    input  logic [3:0]     ARQOS,
    input  logic [3:0]     ARREGION,
    input  logic           ARVALID,
    output logic           ARREADY,
    output logic [I-1:0]   RID,
    output logic [8*N-1:0] RDATA,
    output logic [1:0]     RRESP,
    output logic           RLAST,
    output logic           RVALID,
    input  logic           RREADY
);

    localparam int OFF_W   = $clog2(N);
    localparam int WORD_HI = DEPTH_LOG2 + OFF_W;
    localparam int DEPTH   = 1 << DEPTH_LOG2;

    logic [8*N-1:0] r_mem [DEPTH];

    // Holds AWREADY/ARREADY low until the first edge after reset release.
    logic           r_en;

    wr_state_t      r_wstate, w_wstate_nxt;
    logic [I-1:0]   r_wid;
    logic [A-1:0]   r_waddr, w_wnext;
    logic [7:0]     r_wlen, r_wcnt;
    logic [2:0]     r_wsize;
    logic [1:0]     r_wburst;
    logic           r_werr;
    logic           w_wbeat;
    logic           w_waddr_err;

    rd_state_t      r_rstate, w_rstate_nxt;
    logic [I-1:0]   r_rid;
    logic [A-1:0]   r_raddr, w_rnext;
    logic [7:0]     r_rlen, r_rcnt;
    logic [2:0]     r_rsize;
    logic [1:0]     r_rburst;
    logic [8*N-1:0] r_rdata;
    logic           r_rerr;
    logic           w_araddr_err, w_rnext_err;

    logic           w_unused;
    assign w_unused = &{1'b0, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION,
                        ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, WLAST};

`ifdef AXI4_SLAVE_MEM_RANGE_CHK_EN
    assign w_waddr_err  = |r_waddr[A-1:WORD_HI];
    assign w_araddr_err = |ARADDR[A-1:WORD_HI];
    assign w_rnext_err  = |w_rnext[A-1:WORD_HI];
`else
    assign w_waddr_err  = 1'b0;
    assign w_araddr_err = 1'b0;
    assign w_rnext_err  = 1'b0;
`endif

    axi4_burst_addr #(.A(A)) u_waddr_next (
        .addr      (r_waddr),
        .len       (r_wlen),
        .size      (r_wsize),
        .burst     (r_wburst),
        .next_addr (w_wnext)
    );

    axi4_burst_addr #(.A(A)) u_raddr_next (
        .addr      (r_raddr),
        .len       (r_rlen),
        .size      (r_rsize),
        .burst     (r_rburst),
        .next_addr (w_rnext)
    );

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_en     <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            r_en     <= 1'b1;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        AWREADY      = 1'b0;
        WREADY       = 1'b0;
        BVALID       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                AWREADY = r_en;
                if (AWVALID && r_en) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                // Termination follows the beat count; WLAST is not consulted.
                if (WVALID && (r_wcnt == r_wlen)) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    assign w_wbeat = WVALID && WREADY;
    assign BID     = r_wid;
    assign BRESP   = r_werr ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wid    <= '0;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_werr   <= 1'b0;
        end else if (AWVALID && AWREADY) begin
            r_wid    <= AWID;
            r_waddr  <= AWADDR;
            r_wlen   <= AWLEN;
            r_wcnt   <= '0;
            r_wsize  <= AWSIZE;
            r_wburst <= AWBURST;
            r_werr   <= 1'b0;
        end else if (w_wbeat) begin
            r_waddr <= w_wnext;
            r_wcnt  <= r_wcnt + 8'd1;
            if (w_waddr_err) r_werr <= 1'b1;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge ACLK) begin
        if (w_wbeat && !w_waddr_err) begin
            for (int b = 0; b < N; b++) begin
                if (WSTRB[b]) r_mem[r_waddr[WORD_HI-1:OFF_W]][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        w_rstate_nxt = r_rstate;
        ARREADY      = 1'b0;
        RVALID       = 1'b0;
        RLAST        = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                ARREADY = r_en;
                if (ARVALID && r_en) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                RLAST  = (r_rcnt == r_rlen);
                if (RREADY && (r_rcnt == r_rlen)) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign RID   = r_rid;
    assign RDATA = r_rdata;
    assign RRESP = r_rerr ? RESP_SLVERR : RESP_OKAY;

    // Beat data is captured on the edge that accepts the previous handshake,
    // so it stays stable while RREADY is low and a same-edge write to the
    // word being fetched is seen as old data.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rid    <= '0;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
            r_rdata  <= '0;
            r_rerr   <= 1'b0;
        end else if (ARVALID && ARREADY) begin
            r_rid    <= ARID;
            r_raddr  <= ARADDR;
            r_rlen   <= ARLEN;
            r_rcnt   <= '0;
            r_rsize  <= ARSIZE;
            r_rburst <= ARBURST;
            r_rdata  <= w_araddr_err ? '0 : r_mem[ARADDR[WORD_HI-1:OFF_W]];
            r_rerr   <= w_araddr_err;
        end else if (RVALID && RREADY && !RLAST) begin
            r_raddr <= w_rnext;
            r_rcnt  <= r_rcnt + 8'd1;
            r_rdata <= w_rnext_err ? '0 : r_mem[w_rnext[WORD_HI-1:OFF_W]];
            r_rerr  <= w_rnext_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_slave_mem
// Purpose  : Self-checking bench for axi4_slave_mem. A reference memory model
//            produces expected B and R responses, queued when the request is
//            issued and popped as the DUT responds.
// Config   : AXI4_SLAVE_MEM_RANGE_CHK_EN selects the out-of-range scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_slave_mem;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST;
    logic        AWVALID, AWREADY, ARVALID, ARREADY;
    logic [63:0] WDATA, RDATA;
    logic [7:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic [1:0]  BRESP, RRESP;
    logic        BVALID, BREADY, RLAST, RVALID, RREADY;

    always #5 ACLK = ~ACLK;

    axi4_slave_mem dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(1'b0), .AWCACHE(4'd0), .AWPROT(3'd0), .AWQOS(4'd0), .AWREGION(4'd0),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(1'b0), .ARCACHE(4'd0), .ARPROT(3'd0), .ARQOS(4'd0), .ARREGION(4'd0),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY)
    );

`ifdef AXI4_SLAVE_MEM_RANGE_CHK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [1:0]  resp;
        logic [7:0]  id;
    } rbeat_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] model_mem [0:1023];
    rbeat_t      r_q [$];
    logic [9:0]  b_q [$];
    logic [63:0] wd_buf [16];
    logic [7:0]  ws_buf [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Byte address of beat n, derived directly from the AXI burst rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst,
                                              input int n);
        logic [31:0] step, wb, al, base, nn;
        step = 32'd1 << size;
        wb   = ({24'd0, len} + 32'd1) * step;
        al   = addr & ~(step - 32'd1);
        base = addr & ~(wb - 32'd1);
        nn   = 32'(n) * step;
        if (n == 0 || burst == 2'd0) return addr;
        if (burst == 2'd2) return base + ((al - base + nn) % wb);
        return al + nn;
    endfunction

    function automatic logic out_of_range(input logic [31:0] a);
        return RCHK && (a[31:13] != 19'd0);
    endfunction

    function automatic logic sig_sel(input int w);
        case (w)
            0:       return AWREADY;
            1:       return WREADY;
            2:       return BVALID;
            3:       return ARREADY;
            default: return RVALID;
        endcase
    endfunction

    task automatic wait_hi(input int w, input string tag);
        int t = 0;
        @(negedge ACLK);
        while (!sig_sel(w) && t < 50) begin
            @(negedge ACLK);
            t++;
        end
        if (!sig_sel(w)) check({tag, "_timeout"}, 64'(sig_sel(w)), 64'd1);
    endtask

    task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int bdelay);
        logic [1:0]  resp;
        logic [31:0] a;
        logic [9:0]  e;
        @(posedge ACLK); #1;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        wait_hi(0, "aw");
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        resp = 2'b00;
        for (int n = 0; n <= int'(len); n++) begin
            a = beat_addr(addr, len, size, burst, n);
            if (out_of_range(a)) resp = 2'b10;
            else for (int b = 0; b < 8; b++)
                if (ws_buf[n][b]) model_mem[a[12:3]][b*8 +: 8] = wd_buf[n][b*8 +: 8];
        end
        b_q.push_back({id, resp});
        for (int n = 0; n <= int'(len); n++) begin
            WDATA = wd_buf[n]; WSTRB = ws_buf[n]; WLAST = (n == int'(len)); WVALID = 1'b1;
            wait_hi(1, "w");
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        @(negedge ACLK);
        check("b_latency", 64'(BVALID), 64'd1);
        for (int d = 0; d < bdelay; d++) begin
            @(negedge ACLK);
            check("b_hold_valid", 64'(BVALID), 64'd1);
            check("b_hold_id", 64'(BID), 64'(id));
        end
        if (!BVALID) wait_hi(2, "b");
        BREADY = 1'b1;
        e = b_q.pop_front();
        check("bid", 64'(BID), 64'(e[9:2]));
        check("bresp", 64'(BRESP), 64'(e[1:0]));
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        check("aw_ready_back", 64'(AWREADY), 64'd1);
    endtask

    // abort_at >= 0 asserts ARESET while that beat is on the bus and returns.
    task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int abort_at);
        rbeat_t      e;
        logic [31:0] a;
        int          stalls = 0;
        int          t;
        for (int n = 0; n <= int'(len); n++) begin
            a = beat_addr(addr, len, size, burst, n);
            e.data = out_of_range(a) ? 64'd0 : model_mem[a[12:3]];
            e.resp = out_of_range(a) ? 2'b10 : 2'b00;
            e.last = (n == int'(len));
            e.id   = id;
            r_q.push_back(e);
        end
        @(posedge ACLK); #1;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        wait_hi(3, "ar");
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        RREADY  = 1'b1;
        for (int n = 0; n <= int'(len); n++) begin
            @(negedge ACLK);
            if (n == 0) check("r_latency", 64'(RVALID), 64'd1);
            t = 0;
            while (!RVALID && t < 50) begin
                stalls++;
                t++;
                @(negedge ACLK);
            end
            if (!RVALID) begin
                check("r_timeout", 64'(RVALID), 64'd1);
                break;
            end
            if (n == abort_at) begin
                ARESET = 1'b1;
                #1;
                check("rst_rvalid", 64'(RVALID), 64'd0);
                check("rst_arready", 64'(ARREADY), 64'd0);
                r_q.delete();
                RREADY = 1'b0;
                return;
            end
            e = r_q.pop_front();
            check("rdata", RDATA, e.data);
            check("rlast", 64'(RLAST), 64'(e.last));
            check("rresp", 64'(RRESP), 64'(e.resp));
            check("rid", 64'(RID), 64'(e.id));
        end
        check("r_stream", 64'(stalls), 64'd0);
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        check("ar_ready_back", 64'(ARREADY), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        for (int i = 0; i < 1024; i++) model_mem[i] = '0;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_ctrl", 64'({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST}), 64'd0);
        check("rst_rdata", RDATA, 64'd0);
        ARESET = 1'b0;
        #1;
        check("rel_awready_pre", 64'(AWREADY), 64'd0);
        @(posedge ACLK); #1;
        check("rel_awready", 64'(AWREADY), 64'd1);
        check("rel_arready", 64'(ARREADY), 64'd1);

        // Single beat
        wd_buf[0] = 64'hDEADBEEF12345678; ws_buf[0] = 8'hFF;
        axi_write(8'd0, 32'h2000, 8'd0, 3'd3, 2'd1, 0);
        axi_read(8'd0, 32'h2000, 8'd0, 3'd3, 2'd1, -1);

        // INCR burst, then WRAP read of the same window
        for (int i = 0; i < 4; i++) begin
            wd_buf[i] = 64'(i + 1);
            ws_buf[i] = 8'hFF;
        end
        axi_write(8'd1, 32'h1000, 8'd3, 3'd3, 2'd1, 0);
        axi_read(8'd1, 32'h1000, 8'd3, 3'd3, 2'd1, -1);
        axi_read(8'd2, 32'h1010, 8'd3, 3'd3, 2'd2, -1);

        // Reset during beat 2 of an 8-beat read
        axi_read(8'd3, 32'h1000, 8'd7, 3'd3, 2'd1, 2);
        @(negedge ACLK);
        check("in_rst_rvalid", 64'(RVALID), 64'd0);
        ARESET = 1'b0;
        #1;
        check("rel2_arready_pre", 64'(ARREADY), 64'd0);
        @(posedge ACLK); #1;
        check("rel2_arready", 64'(ARREADY), 64'd1);
        axi_read(8'd4, 32'h1000, 8'd3, 3'd3, 2'd1, -1);

        // Strobes and B backpressure
        wd_buf[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws_buf[0] = 8'hFF;
        axi_write(8'd5, 32'h3000, 8'd0, 3'd3, 2'd1, 0);
        wd_buf[0] = 64'h1122334455667788; ws_buf[0] = 8'h0F;
        axi_write(8'd6, 32'h3000, 8'd0, 3'd3, 2'd1, 5);
        axi_read(8'd6, 32'h3000, 8'd0, 3'd3, 2'd1, -1);

        // FIXED burst: both beats land on the same word
        wd_buf[0] = 64'hAAAA_0000_0000_0001; ws_buf[0] = 8'hFF;
        wd_buf[1] = 64'hBBBB_0000_0000_0002; ws_buf[1] = 8'hFF;
        axi_write(8'd7, 32'h0500, 8'd1, 3'd3, 2'd0, 0);
        axi_read(8'd7, 32'h0500, 8'd1, 3'd3, 2'd0, -1);

        // Narrow 4-byte INCR: two beats fill the two halves of one word
        wd_buf[0] = 64'h0000_0000_CAFE_F00D; ws_buf[0] = 8'h0F;
        wd_buf[1] = 64'h1234_5678_0000_0000; ws_buf[1] = 8'hF0;
        axi_write(8'd8, 32'h0600, 8'd1, 3'd2, 2'd1, 0);
        axi_read(8'd8, 32'h0600, 8'd0, 3'd3, 2'd1, -1);

`ifdef AXI4_SLAVE_MEM_RANGE_CHK_EN
        wd_buf[0] = 64'h0123_4567_89AB_CDEF; ws_buf[0] = 8'hFF;
        axi_write(8'd9, 32'h0000_0000, 8'd0, 3'd3, 2'd1, 0);
        wd_buf[0] = 64'hBAD0_BAD0_BAD0_BAD0;
        axi_write(8'd10, 32'h8000_0000, 8'd0, 3'd3, 2'd1, 0);
        axi_read(8'd10, 32'h0000_0000, 8'd0, 3'd3, 2'd1, -1);
        axi_read(8'd11, 32'h8000_0000, 8'd0, 3'd3, 2'd1, -1);
`else
        wd_buf[0] = 64'hA5A5_5A5A_0F0F_F0F0; ws_buf[0] = 8'hFF;
        axi_write(8'd9, 32'h8000_0000, 8'd0, 3'd3, 2'd1, 0);
        axi_read(8'd10, 32'h0000_0000, 8'd0, 3'd3, 2'd1, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_slave_mem.md
# axi4_slave_mem

AXI4 memory responder sitting opposite the `Axi4MasterBFM` on an `AXI4` interface instance. It accepts one write burst and one read burst at a time on independent read/write paths, backs them with an internal word-addressed RAM, and returns B/R responses. It is the DUT-side target for bench traffic such as a single 64-bit beat to 0x2000 or a read from 0x1000.

## Interface
- N, 8: data bus width in bytes; log2(N) is the byte-offset width.
- I, 8: ID width.
- A, 32: address width.
- DEPTH_LOG2, 10: log2 of RAM depth in N-byte words.

- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  I/A/8/3/2  write address; AWLOCK/AWCACHE/AWPROT/AWQOS/AWREGION are accepted and ignored.
- AWVALID  in  1; AWREADY  out  1.
- WDATA/WSTRB/WLAST  in  8N/N/1; WVALID  in  1; WREADY  out  1.
- BID/BRESP  out  I/2; BVALID  out  1; BREADY  in  1.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  I/A/8/3/2; other AR sideband fields are ignored.
- ARVALID  in  1; ARREADY  out  1.
- RID/RDATA/RRESP/RLAST  out  I/8N/2/1; RVALID  out  1; RREADY  in  1.

## Operation
- Write FSM:
  - W_IDLE: AWREADY=1. On an AW handshake, latch id, addr, len, size and burst; clear beat count; go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes RAM[word] under WSTRB byte enables, then advances the address. On the handshake where count==len, go to W_RESP. Termination uses the beat count; WLAST is informational only.
  - W_RESP: BVALID=1 with BID=latched id and BRESP=OKAY. Hold until BREADY, then return to W_IDLE.
- Read FSM:
  - R_IDLE: ARREADY=1. On an AR handshake, latch the fields and go to R_DATA.
  - R_DATA: RVALID=1 with RDATA=RAM[word], RID=latched id, RRESP=OKAY and RLAST=(count==len).
    - On each R handshake, advance the address and count; the next beat is presented in the following cycle.
    - On the handshake of the last beat, return to R_IDLE.
- Address arithmetic:
  - word = addr[DEPTH_LOG2+log2(N)-1 : log2(N)]; upper address bits are ignored, so the RAM aliases.
  - Step is 1<<size, with size ≤ log2(N) required.
  - FIXED (0): address unchanged.
  - INCR (1): after the first beat, the address is aligned to the size and then incremented by the step.
  - WRAP (2): wraps within an aligned window of (len+1)<<size bytes; len must be 1, 3, 7 or 15.
  - Burst value 3 is treated as INCR.
- Narrow transfers: the full word is returned on reads; on writes, only strobed bytes change.
- Read/write collision: a write beat and a read beat to the same word in the same cycle return the old data to the read.
- RAM contents are not reset.

## Timing
- During reset, all outputs are 0. AWREADY and ARREADY rise at the first ACLK edge after ARESET falls.
- Reset asserted mid-burst aborts both FSMs immediately:
  - VALID/READY outputs go low asynchronously.
  - Partially written data remains in the RAM.
- Latencies:
  - AW handshake at edge k: WREADY is high from k+1.
  - Last W handshake at edge m: BVALID is high from m+1.
  - AR handshake at edge k: RVALID with beat 0 from k+1.
- With RREADY held high, a burst streams one beat per cycle.
- The next AR is accepted one cycle after the RLAST handshake; likewise, the next AW is accepted one cycle after the B handshake.
- AXI stability: once RVALID or BVALID is asserted, it and its payload stay stable until the corresponding READY. No VALID depends combinationally on a READY.

## Configuration
- AXI4_SLAVE_MEM_RANGE_CHK_EN:
  - Defined: any beat whose address has bits set above A'(DEPTH_LOG2+log2(N)) gets SLVERR (2'b10).
    - Writes to such addresses are suppressed and BRESP=SLVERR if any beat errored.
    - Reads return RDATA=0 with RRESP=SLVERR on the offending beat.
  - Undefined: addresses alias silently and all responses are OKAY.

## Structure
- Shared package pkg_Axi4Types (existing) holds:
  - burst encodings FIXED/INCR/WRAP;
  - response codes OKAY/EXOKAY/SLVERR/DECERR;
  - the write and read FSM state enums.
- One sub-module, axi4_burst_addr:
  - combinational next-address calculation from (addr, len, size, burst);
  - instantiated once for the write path and once for the read path.

## Test plan
- Write AW id=0, addr=0x2000, len=0, size=3, INCR with W data=0xDEADBEEF12345678, strb=0xFF; then read 0x2000 -> BRESP=OKAY, BID=0; RDATA=0xDEADBEEF12345678, RLAST=1, RID=0.
- INCR burst: write len=3, size=3 at 0x1000 with data 1,2,3,4; read len=3 -> beats 1,2,3,4 in order, RLAST only on beat 3, and one beat per cycle with RREADY=1.
- WRAP burst: read len=3, size=3 at 0x1010 after the INCR test -> data 3,4,1,2.
- Strobe and backpressure:
  - Write 0x3000 with 0xFFFF_FFFF_FFFF_FFFF, then write 0x1122334455667788 with strb=0x0F; read 0x3000 -> 0xFFFFFFFF55667788.
  - With BREADY low for 5 cycles, BVALID and BID are held stable.
- Reset mid-burst: assert ARESET during beat 2 of a len=7 read -> RVALID=0 immediately; ARREADY=1 one edge after release; a new read completes normally.
- With AXI4_SLAVE_MEM_RANGE_CHK_EN defined: write to 0x8000_0000 -> BRESP=2'b10 and RAM unchanged; read from 0x8000_0000 -> RRESP=2'b10 and RDATA=0.
